// File: rtl/mem_interface_pkg.sv
// Shared request/response bundles and FSM state for the piped data memory.
package mem_interface_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    typedef struct packed {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
    } mem_resp_t;

    typedef enum logic {
        INIT,
        RUN
    } mem_state_t;

    localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/mem_resp_pipe.sv
// Delay line for {valid, err, data} response slots; STAGES = 0 is a plain wire-through.
module mem_resp_pipe #(
    parameter int STAGES = 0,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_err,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_err,
    output logic [WIDTH-1:0] o_data
);
    localparam int SW = WIDTH + 2;

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unusedClkRst;
            assign w_unusedClkRst = clk ^ rst;
            assign {o_valid, o_err, o_data} = {i_valid, i_err, i_data};
        end else begin : g_shift
            logic [STAGES-1:0][SW-1:0] r_stage;
            logic [STAGES:0][SW-1:0]   w_shifted;

            // Data shifts along with valid, so the last stage keeps the most recent read's data.
            assign w_shifted = {r_stage, i_valid, i_err, i_data};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_shifted[STAGES-1:0];
                end
            end

            assign {o_valid, o_err, o_data} = w_shifted[STAGES];
        end
    endgenerate

endmodule

// File: rtl/data_memory_piped.sv
// Word-addressed 32-bit memory with byte enables, an optional post-reset zeroing sweep
// and a fully pipelined, in-order read response path of READ_LATENCY cycles.
module data_memory_piped
    import mem_interface_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int ZERO_INIT    = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  mem_req_t  req,
    output mem_resp_t resp,
    output logic      resp_err,
    output logic      init_done
);
    localparam int            AW          = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH - 1);
    localparam mem_state_t    RESET_STATE = (ZERO_INIT != 0) ? INIT : RUN;
    localparam int            CLAMP_LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY
                                          : (READ_LATENCY < 1) ? 1 : READ_LATENCY;

    mem_state_t    r_state;
    mem_state_t    w_stateNext;
    logic [AW-1:0] r_initIdx;
    logic [31:0]   r_mem [DEPTH];

    logic          w_ready;
    logic          w_accept;
    logic          w_read;
    logic          w_write;
    logic          w_outOfRange;
    logic [AW-1:0] w_wordIdx;
    logic [31:0]   w_byteMask;
    logic          w_unusedAddr;

    logic          r_s1Valid;
    logic          r_s1Err;
    logic [31:0]   r_s1Data;
    logic          w_outValid;
    logic          w_outErr;
    logic [31:0]   w_outData;

    assign w_ready      = (r_state == RUN);
    assign w_accept     = req.valid & w_ready;
    assign w_read       = w_accept & ~req.we;
    assign w_outOfRange = |req.addr[31:AW+2];
    assign w_write      = w_accept & req.we & ~w_outOfRange;
    assign w_wordIdx    = req.addr[AW+1:2];
    assign w_byteMask   = {{8{req.be[3]}}, {8{req.be[2]}}, {8{req.be[1]}}, {8{req.be[0]}}};
    assign w_unusedAddr = ^req.addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RESET_STATE;
            r_initIdx <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == INIT) begin
                r_initIdx <= r_initIdx + 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            INIT: if (r_initIdx == LAST_IDX) w_stateNext = RUN;
            RUN:  w_stateNext = RUN;
        endcase
    end

    // The array itself has no reset; the INIT sweep is the only way it gets cleared.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_initIdx] <= '0;
        end else if (w_write) begin
            r_mem[w_wordIdx] <= (r_mem[w_wordIdx] & ~w_byteMask) | (req.wdata & w_byteMask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            r_s1Err   <= 1'b0;
            r_s1Data  <= '0;
        end else begin
            r_s1Valid <= w_read;
            r_s1Err   <= w_accept & w_outOfRange;
            if (w_read) begin
                r_s1Data <= w_outOfRange ? 32'h0 : r_mem[w_wordIdx];
            end
        end
    end

    mem_resp_pipe #(
        .STAGES(CLAMP_LAT - 1),
        .WIDTH (32)
    ) u_respPipe (
        .clk    (clk),
        .rst    (rst),
        .i_valid(r_s1Valid),
        .i_err  (r_s1Err),
        .i_data (r_s1Data),
        .o_valid(w_outValid),
        .o_err  (w_outErr),
        .o_data (w_outData)
    );

    assign resp      = '{ready: w_ready, rvalid: w_outValid, rdata: w_outData};
    assign resp_err  = w_outErr;
    assign init_done = w_ready;

endmodule

// File: tb/tb_data_memory_piped.sv
// Scoreboard bench: instance A (latency 3) runs directed traffic checked by a monitor,
// instance B (latency 4) covers reset during INIT and reset with a read in flight.
`timescale 1ns/1ps
module tb_data_memory_piped;
    import mem_interface_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT_A = 3;
    localparam int LAT_B = 4;

    typedef struct {
        logic        rvalid;
        logic        err;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic      clk = 1'b0;
    logic      rstA;
    logic      rstB;
    mem_req_t  reqA;
    mem_req_t  reqB;
    mem_resp_t respA;
    mem_resp_t respB;
    logic      errA;
    logic      errB;
    logic      doneA;
    logic      doneB;

    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    exp_t        sbq[$];
    logic [31:0] lastDataA;
    int          rvalidCountB = 0;
    logic        countBEn = 1'b0;

    data_memory_piped #(.DEPTH(DEPTH), .READ_LATENCY(LAT_A), .ZERO_INIT(1)) dutA (
        .clk      (clk),
        .rst      (rstA),
        .req      (reqA),
        .resp     (respA),
        .resp_err (errA),
        .init_done(doneA)
    );

    data_memory_piped #(.DEPTH(DEPTH), .READ_LATENCY(LAT_B), .ZERO_INIT(1)) dutB (
        .clk      (clk),
        .rst      (rstB),
        .req      (reqB),
        .resp     (respB),
        .resp_err (errB),
        .init_done(doneB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drives one request on A; the response it should produce is queued for the monitor.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] expData, input logic expErr);
        exp_t e;
        reqA = '{valid: 1'b1, we: we, addr: addr, wdata: wdata, be: be};
        if (!we || expErr) begin
            e.rvalid = !we;
            e.err    = expErr;
            e.data   = expData;
            e.cycle  = cycleCount + LAT_A;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        reqA.valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        reqA.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic countInitB(output int n);
        n = 0;
        while (!respB.ready && n < 100) begin
            @(negedge clk);
            if (!respB.ready) n++;
        end
    endtask

    always @(negedge clk) begin : monitorA
        exp_t e;
        if (!rstA) begin
            lastDataA = '0;
        end else if (respA.rvalid || errA) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp actual rvalid=%0b err=%0b expected no response", respA.rvalid, errA);
            end else begin
                e = sbq.pop_front();
                checkOutput("resp_rvalid", 32'(respA.rvalid), 32'(e.rvalid));
                checkOutput("resp_err", 32'(errA), 32'(e.err));
                checkOutput("resp_cycle", cycleCount, e.cycle);
                if (e.rvalid) begin
                    checkOutput("resp_rdata", respA.rdata, e.data);
                    lastDataA = e.data;
                end else begin
                    checkOutput("rdata_hold", respA.rdata, lastDataA);
                end
            end
        end else begin
            checkOutput("rdata_hold", respA.rdata, lastDataA);
        end
    end

    always @(negedge clk) begin
        if (countBEn && respB.rvalid) rvalidCountB++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rstA = 1'b0;
        rstB = 1'b0;
        reqA = '0;
        reqB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(respA.ready), 32'd0);
        checkOutput("reset_rvalid", 32'(respA.rvalid), 32'd0);
        checkOutput("reset_err", 32'(errA), 32'd0);
        checkOutput("reset_rdata", respA.rdata, 32'd0);
        checkOutput("reset_init_done", 32'(doneA), 32'd0);

        // Release A and hammer it with requests that must be ignored during INIT.
        rstA = 1'b1;
        reqA = '{valid: 1'b1, we: 1'b1, addr: 32'h4, wdata: 32'hDEADBEEF, be: 4'hF};
        n = 0;
        while (!respA.ready && n < 100) begin
            @(negedge clk);
            if (!respA.ready) begin
                n++;
                reqA.we = ~reqA.we;
            end
        end
        reqA.valid = 1'b0;
        checkOutput("init_cycles", n, 32'd16);
        checkOutput("init_done", 32'(doneA), 32'd1);
        checkOutput("ready_run", 32'(respA.ready), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 32'h00000000, 1'b0);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 32'h00000000, 1'b0);

        applyStimulus(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h08, 32'h12345678, 4'h5, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 32'hFF34FF78, 1'b0);
        applyStimulus(1'b1, 32'h08, 32'hAAAAAAAA, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 32'hFF34FF78, 1'b0);
        applyStimulus(1'b1, 32'h08, 32'h00000000, 4'hA, 32'h0, 1'b0);

        applyStimulus(1'b1, 32'h00, 32'h11111111, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h04, 32'h22222222, 4'hF, 32'h0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 32'h11111111, 1'b0);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 32'h22222222, 1'b0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 32'h00340078, 1'b0);
        idleCycles(5);

        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h00000000, 1'b1);
        idleCycles(4);
        applyStimulus(1'b1, 32'h40, 32'h55555555, 4'hF, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h80000004, 32'h66666666, 4'hF, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 32'h11111111, 1'b0);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 32'h22222222, 1'b0);
        applyStimulus(1'b0, 32'h07, 32'h0, 4'h0, 32'h22222222, 1'b0);

        applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("scoreboard_drain", 32'(sbq.size()), 32'd0);

        // B: reset part-way through INIT must restart the sweep from index 0.
        rstB = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rstB = 1'b0;
        @(posedge clk);
        #1;
        rstB = 1'b1;
        countInitB(n);
        checkOutput("b_restart_init_cycles", n, 32'd16);
        @(posedge clk);
        #1;

        reqB = '{valid: 1'b1, we: 1'b1, addr: 32'h0, wdata: 32'h0BADCAFE, be: 4'hF};
        @(posedge clk);
        #1;
        reqB = '{valid: 1'b1, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
        @(posedge clk);
        #1;
        reqB.valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!respB.rvalid && n < 10);
        checkOutput("b_latency", n, 32'd4);
        checkOutput("b_rdata", respB.rdata, 32'h0BADCAFE);
        @(negedge clk);
        checkOutput("b_rvalid_one_cycle", 32'(respB.rvalid), 32'd0);
        checkOutput("b_rdata_hold", respB.rdata, 32'h0BADCAFE);

        // B: read in flight when reset hits must never surface.
        @(posedge clk);
        #1;
        rvalidCountB = 0;
        countBEn = 1'b1;
        reqB = '{valid: 1'b1, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
        @(posedge clk);
        #1;
        reqB.valid = 1'b0;
        @(posedge clk);
        #1;
        rstB = 1'b0;
        #1;
        checkOutput("b_async_rdata", respB.rdata, 32'h0);
        checkOutput("b_async_rvalid", 32'(respB.rvalid), 32'd0);
        checkOutput("b_async_ready", 32'(respB.ready), 32'd0);
        checkOutput("b_async_init_done", 32'(doneB), 32'd0);
        @(posedge clk);
        #1;
        rstB = 1'b1;
        countInitB(n);
        checkOutput("b_reinit_cycles", n, 32'd16);
        repeat (6) @(posedge clk);
        #1;
        countBEn = 1'b0;
        checkOutput("b_midflight_rvalid", rvalidCountB, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
